// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding, default parameter values and the mask-scan
// helper for the SAR ADC bank sequencer.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        SETTLE = 3'd2,
        LATCH  = 3'd3,
        DONE   = 3'd4
    } sar_state_e;

    localparam int SAR_NUM_ADC_DEF       = 8;
    localparam int SAR_NUM_BITS_DEF      = 10;
    localparam int SAR_SAMPLE_CYCLES_DEF = 2;
    localparam int SAR_SETTLE_CYCLES_DEF = 4;

    // Widest mask the scan helper handles; NUM_ADC must not exceed it.
    localparam int SAR_MAX_ADC = 32;

    // Lowest set index in mask at or above 'from'; SAR_MAX_ADC when none is set.
    function automatic int sar_next_set(input logic [SAR_MAX_ADC-1:0] mask,
                                        input int from);
        int idx;
        idx = SAR_MAX_ADC;
        for (int i = SAR_MAX_ADC - 1; i >= 0; i--) begin
            if ((i >= from) && mask[i]) begin
                idx = i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sar_phase_timer.sv
// sar_phase_timer: loadable down-counter with a zero flag, timing both the
// SAMPLE and SETTLE phases. Load takes priority; the count stops at zero.
module sar_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Phase counter: reload on state entry, otherwise count down to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/sar_sequencer.sv
// sar_sequencer: steps a bank of SAR ADCs (ascending index, masked) through
// sample and MSB-first bit trials. All outputs are registered from the next
// state. Optional macro SAR_ABORT_EN adds an 'abort' input that returns any
// active sweep to IDLE without a done pulse.
module sar_sequencer
    import sar_pkg::*;
#(
    parameter int NUM_ADC       = SAR_NUM_ADC_DEF,
    parameter int NUM_BITS      = SAR_NUM_BITS_DEF,
    parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SAR_SETTLE_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_ADC-1:0]  adc_mask,
`ifdef SAR_ABORT_EN
    input  logic                abort,
`endif
    output logic [NUM_ADC-1:0]  adc_sel,
    output logic [NUM_BITS-1:0] bit_sel,
    output logic [NUM_ADC-1:0]  wr_adc,
    output logic                sample,
    output logic                bit_valid,
    output logic                busy,
    output logic                done
);

    localparam int AIW  = (NUM_ADC > 1) ? $clog2(NUM_ADC) : 1;
    localparam int BIW  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(CMAX + 1);

    sar_state_e         r_state, w_state_nx;
    logic [NUM_ADC-1:0] r_mask, w_mask_nx;
    logic [AIW-1:0]     r_adc_idx, w_adc_idx_nx;
    logic [BIW-1:0]     r_bit_idx, w_bit_idx_nx;
    logic               w_tmr_load, w_tmr_dec, w_tmr_zero;
    logic [TW-1:0]      w_tmr_val;
    int                 w_first_idx, w_next_idx;
    logic               w_abort;

    logic [NUM_ADC-1:0]  r_adc_sel, r_wr_adc, w_adc_sel_nx, w_wr_adc_nx;
    logic [NUM_BITS-1:0] r_bit_sel, w_bit_sel_nx;
    logic                r_sample, r_bit_valid, r_busy, r_done;

`ifdef SAR_ABORT_EN
    assign w_abort = abort && (r_state != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Mask scans: first ADC of a new sweep and the next ADC after the current one.
    assign w_first_idx = sar_next_set(SAR_MAX_ADC'(adc_mask), 0);
    assign w_next_idx  = sar_next_set(SAR_MAX_ADC'(r_mask), int'(r_adc_idx) + 1);

    sar_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    // Next-state logic: phase sequencing, index stepping and timer control.
    always_comb begin
        w_state_nx   = r_state;
        w_mask_nx    = r_mask;
        w_adc_idx_nx = r_adc_idx;
        w_bit_idx_nx = r_bit_idx;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_tmr_dec    = 1'b0;
        if (w_abort) begin
            w_state_nx = IDLE;
            w_mask_nx  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && (adc_mask != '0)) begin
                        w_mask_nx    = adc_mask;
                        w_adc_idx_nx = AIW'(w_first_idx);
                        w_state_nx   = SAMPLE;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = TW'(SAMPLE_CYCLES - 1);
                    end else if (start) begin
                        w_state_nx = DONE;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
                SAMPLE: begin
                    if (w_tmr_zero) begin
                        w_state_nx   = SETTLE;
                        w_bit_idx_nx = BIW'(NUM_BITS - 1);
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = TW'(SETTLE_CYCLES - 1);
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_tmr_zero) begin
                        w_state_nx = LATCH;
                    end else begin
                        w_tmr_dec = 1'b1;
                    end
                end
                LATCH: begin
                    if (r_bit_idx != '0) begin
                        w_bit_idx_nx = r_bit_idx - BIW'(1);
                        w_state_nx   = SETTLE;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = TW'(SETTLE_CYCLES - 1);
                    end else if (w_next_idx < NUM_ADC) begin
                        w_adc_idx_nx = AIW'(w_next_idx);
                        w_state_nx   = SAMPLE;
                        w_tmr_load   = 1'b1;
                        w_tmr_val    = TW'(SAMPLE_CYCLES - 1);
                    end else begin
                        w_state_nx = DONE;
                    end
                end
                DONE: begin
                    w_state_nx = IDLE;
                    w_mask_nx  = '0;
                end
                default: begin
                    w_state_nx = IDLE;
                    w_mask_nx  = '0;
                end
            endcase
        end
    end

    // Moore output decode from the next state, registered below.
    always_comb begin
        w_adc_sel_nx = '0;
        w_bit_sel_nx = '0;
        w_wr_adc_nx  = '0;
        if ((w_state_nx == SAMPLE) || (w_state_nx == SETTLE) || (w_state_nx == LATCH)) begin
            w_adc_sel_nx = NUM_ADC'(1'b1) << w_adc_idx_nx;
        end else begin
            w_adc_sel_nx = '0;
        end
        if ((w_state_nx == SETTLE) || (w_state_nx == LATCH)) begin
            w_bit_sel_nx = NUM_BITS'(1'b1) << w_bit_idx_nx;
        end else begin
            w_bit_sel_nx = '0;
        end
        if (w_state_nx == LATCH) begin
            w_wr_adc_nx = w_adc_sel_nx;
        end else begin
            w_wr_adc_nx = '0;
        end
    end

    // State, sweep context and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_adc_idx   <= '0;
            r_bit_idx   <= '0;
            r_adc_sel   <= '0;
            r_bit_sel   <= '0;
            r_wr_adc    <= '0;
            r_sample    <= 1'b0;
            r_bit_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_mask      <= w_mask_nx;
            r_adc_idx   <= w_adc_idx_nx;
            r_bit_idx   <= w_bit_idx_nx;
            r_adc_sel   <= w_adc_sel_nx;
            r_bit_sel   <= w_bit_sel_nx;
            r_wr_adc    <= w_wr_adc_nx;
            r_sample    <= (w_state_nx == SAMPLE);
            r_bit_valid <= (w_state_nx == LATCH);
            r_busy      <= (w_state_nx != IDLE) && (w_state_nx != DONE);
            r_done      <= (w_state_nx == DONE);
        end
    end

    assign adc_sel   = r_adc_sel;
    assign bit_sel   = r_bit_sel;
    assign wr_adc    = r_wr_adc;
    assign sample    = r_sample;
    assign bit_valid = r_bit_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_sar_sequencer.sv
// tb_sar_sequencer: directed vectors for sar_sequencer at default parameters.
// Expected per-cycle outputs come from a closed-form timeline (52 cycles per
// selected ADC: 2 sample, then 10 x (4 settle + 1 latch), then one DONE cycle).
module tb_sar_sequencer;

    localparam int PER_ADC = 2 + 10 * (4 + 1);

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] adc_mask;
`ifdef SAR_ABORT_EN
    logic       abort;
`endif
    logic [7:0] adc_sel;
    logic [9:0] bit_sel;
    logic [7:0] wr_adc;
    logic       sample, bit_valid, busy, done;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] mask;
        int         exp_done;
        int         exp_valids;
    } vec_t;

    vec_t vecs[5];

    sar_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .adc_mask  (adc_mask),
`ifdef SAR_ABORT_EN
        .abort     (abort),
`endif
        .adc_sel   (adc_sel),
        .bit_sel   (bit_sel),
        .wr_adc    (wr_adc),
        .sample    (sample),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [29:0] observed();
        return {adc_sel, bit_sel, wr_adc, sample, bit_valid, busy, done};
    endfunction

    // Expected {adc_sel, bit_sel, wr_adc, sample, bit_valid, busy, done} at
    // cycle c, where cycle 0 is the cycle in which start is sampled.
    function automatic logic [29:0] exp_out(input logic [7:0] mask, input int c);
        int n, k, o, p, b, r, adc, cnt;
        logic [7:0] a;
        logic [9:0] bs;
        logic [29:0] e;
        e = '0;
        n = $countones(mask);
        if (c == n * PER_ADC + 1) begin
            e[0] = 1'b1;
        end else if ((c >= 1) && (c <= n * PER_ADC)) begin
            k = (c - 1) / PER_ADC;
            o = (c - 1) % PER_ADC;
            adc = 0;
            cnt = 0;
            for (int i = 0; i < 8; i++) begin
                if (mask[i]) begin
                    if (cnt == k) adc = i;
                    cnt++;
                end
            end
            a = 8'h01 << adc;
            if (o < 2) begin
                e = {a, 10'h000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
            end else begin
                p  = o - 2;
                b  = p / 5;
                r  = p % 5;
                bs = 10'h200 >> b;
                if (r == 4) e = {a, bs, a, 1'b0, 1'b1, 1'b1, 1'b0};
                else        e = {a, bs, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input int c, input logic [29:0] got, input logic [29:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got adc_sel=%h bit_sel=%h wr_adc=%h s/v/b/d=%b, expected adc_sel=%h bit_sel=%h wr_adc=%h s/v/b/d=%b",
                     name, c, got[29:22], got[21:12], got[11:4], got[3:0],
                     exp[29:22], exp[21:12], exp[11:4], exp[3:0]);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One sweep: start at cycle 0, compare every cycle through one past done.
    // With disturb set, start and an all-ones mask are driven from cycle 10 on.
    task automatic run_sweep(input logic [7:0] mask, input int exp_done,
                             input int exp_valids, input bit disturb);
        int valids;
        int done_at;
        valids  = 0;
        done_at = -1;
        @(negedge clk);
        start    = 1'b1;
        adc_mask = mask;
        @(posedge clk);
        #1;
        start    = 1'b0;
        adc_mask = 8'h5A;
        for (int c = 1; c <= exp_done + 1; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (disturb && (c == 10)) begin
                start    = 1'b1;
                adc_mask = 8'hFF;
            end
            check("sweep", c, observed(), exp_out(mask, c));
            if (bit_valid) valids++;
            if (done && (done_at < 0)) done_at = c;
        end
        check_int("bit_valid_count", valids, exp_valids);
        check_int("done_cycle", done_at, exp_done);
    endtask

    initial begin
        vecs[0] = '{mask: 8'h01, exp_done: 53,  exp_valids: 10};
        vecs[1] = '{mask: 8'h84, exp_done: 105, exp_valids: 20};
        vecs[2] = '{mask: 8'h00, exp_done: 1,   exp_valids: 0};
        vecs[3] = '{mask: 8'h80, exp_done: 53,  exp_valids: 10};
        vecs[4] = '{mask: 8'hFF, exp_done: 417, exp_valids: 80};

        reset    = 1'b1;
        start    = 1'b0;
        adc_mask = 8'h00;
`ifdef SAR_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 0, observed(), 30'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 0, observed(), 30'h0);

        for (int v = 0; v < 5; v++) begin
            run_sweep(vecs[v].mask, vecs[v].exp_done, vecs[v].exp_valids, 1'b0);
        end

        // Asynchronous reset during the SETTLE phase at cycle 20.
        @(negedge clk);
        start    = 1'b1;
        adc_mask = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 2; c <= 20; c++) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_c20", 20, observed(), exp_out(8'h01, 20));
        #1;
        reset = 1'b1;
        #1;
        check("async_reset", 20, observed(), 30'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_midreset", 21, observed(), 30'h0);

        // start and mask changes mid-sweep are ignored; a start held through
        // DONE is accepted only once back in IDLE.
        run_sweep(8'h01, 53, 10, 1'b1);
        @(posedge clk);
        #1;
        start    = 1'b0;
        adc_mask = 8'h00;
        check("restart_after_done", 55, observed(), {8'h01, 10'h000, 8'h00, 4'b1010});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

`ifdef SAR_ABORT_EN
        // Abort at the third LATCH (cycle 17) returns to IDLE without done.
        @(negedge clk);
        start    = 1'b1;
        adc_mask = 8'h01;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 2; c <= 17; c++) begin
            @(posedge clk);
            #1;
        end
        check("third_latch", 17, observed(), exp_out(8'h01, 17));
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_idle", 18, observed(), 30'h0);
        @(posedge clk);
        #1;
        check("abort_no_done", 19, observed(), 30'h0);
        run_sweep(8'h01, 53, 10, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
